// File: rtl/pc_fetch_stage.sv
// Program counter and instruction-fetch controller for the LEGv8 core.
// Drives the instruction-memory request and fills an IF/ID register with stall/flush support.
module pc_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] next_pc,
   input  logic        stall,
   input  logic        flush,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DRAIN   = 2'd2,
      STALLED = 2'd3
   } state_t;

   state_t      state, state_d;
   logic [31:0] pc_d;
   logic        valid_d;
   logic [31:0] id_pc_d, id_instr_d;
   logic [31:0] buf_instr, buf_instr_d;
   logic [31:0] buf_pc, buf_pc_d;
   logic [31:0] redirect, redirect_d;
   logic [31:0] target;

   assign target    = {next_pc[31:2], 2'b00};
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign imem_req  = (state == FETCH) || (state == DRAIN);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d     = state;
      pc_d        = pc;
      valid_d     = if_id_valid;
      id_pc_d     = if_id_pc;
      id_instr_d  = if_id_instr;
      buf_instr_d = buf_instr;
      buf_pc_d    = buf_pc;
      redirect_d  = redirect;

      unique case (state)
         IDLE: state_d = FETCH;

         FETCH: begin
            if (imem_ready) begin
               if (flush) begin
                  pc_d    = target;
                  valid_d = 1'b0;
               end else if (stall) begin
                  buf_instr_d = imem_rdata;
                  buf_pc_d    = pc;
                  state_d     = STALLED;
               end else begin
                  valid_d    = 1'b1;
                  id_pc_d    = pc;
                  id_instr_d = imem_rdata;
                  pc_d       = target;
               end
            end else if (flush) begin
               redirect_d = target;
               valid_d    = 1'b0;
               state_d    = DRAIN;
            end else if (!stall) begin
               valid_d = 1'b0;
            end
         end

         // Old request still outstanding: its word is discarded, the newest flush target wins.
         DRAIN: begin
            if (flush) redirect_d = target;
            if (imem_ready) begin
               pc_d    = flush ? target : redirect;
               state_d = FETCH;
            end
         end

         STALLED: begin
            if (flush) begin
               pc_d    = target;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (!stall) begin
               valid_d    = 1'b1;
               id_pc_d    = buf_pc;
               id_instr_d = buf_instr;
               pc_d       = target;
               state_d    = FETCH;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_pc    <= 32'd0;
         if_id_instr <= 32'd0;
         buf_instr   <= 32'd0;
         buf_pc      <= 32'd0;
         redirect    <= 32'd0;
      end else begin
         state       <= state_d;
         pc          <= pc_d;
         if_id_valid <= valid_d;
         if_id_pc    <= id_pc_d;
         if_id_instr <= id_instr_d;
         buf_instr   <= buf_instr_d;
         buf_pc      <= buf_pc_d;
         redirect    <= redirect_d;
      end
   end

endmodule
